// File: rtl/sa_pkg.sv
// Shared constants, FSM state type and operand lane helper for the systolic array.
package sa_pkg;

  localparam int unsigned SA_DIM    = 4;
  localparam int unsigned FLUSH_CYC = 2 * SA_DIM - 1;
  localparam int unsigned LANE_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DRAIN
  } sa_state_e;

  // Extract operand byte idx from a packed beat word.
  function automatic logic [LANE_W-1:0] lane_slice(
    input logic [SA_DIM*LANE_W-1:0] v,
    input int unsigned              idx
  );
    return v[idx*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/sa_pe.sv
// One output-stationary PE: multiply-accumulate, forward weight right and input down.
module sa_pe #(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] x_in,
  output logic [DATA_W-1:0] w_out,
  output logic [DATA_W-1:0] x_out,
  output logic [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;

  assign prod = $signed(w_in) * $signed(x_in);

  // Accumulate the signed product (sign-extended, wrapping) and pass operands on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      w_out <= '0;
      x_out <= '0;
    end else if (clr) begin
      acc   <= '0;
      w_out <= '0;
      x_out <= '0;
    end else begin
      acc   <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
      w_out <= w_in;
      x_out <= x_in;
    end
  end

endmodule

// File: rtl/sa_core.sv
// 4x4 output-stationary int8 systolic array: operand skew, PE grid, flush and row drain.
module sa_core
  import sa_pkg::*;
#(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sa_start,
  output logic                    sa_busy,
  input  logic [2:0]              sa_row_en,
  input  logic                    sa_i_vaild,
  input  logic                    sa_i_last,
  input  logic [31:0]             sa_weight,
  input  logic [31:0]             sa_input,
  output logic                    sa_o_valid,
  output logic                    sa_o_last,
  output logic [SA_DIM*ACC_W-1:0] sa_o_data
);

  localparam int unsigned ROW_W = $clog2(SA_DIM);

  sa_state_e              state_q, state_d;
  logic [2:0]             flush_cnt;
  logic [2:0]             row_en_q;
  logic [ROW_W-1:0]       cur_row;
  logic                   accept;
  logic                   flush_done;
  logic                   emit;
  logic [SA_DIM*LANE_W-1:0] inj_w, inj_x;

  logic [SA_DIM-1:0]        en4;
  logic [2:0]               start_idx;
  logic                     found;
  logic [ROW_W-1:0]         nxt_row;
  logic                     nxt_last;
  logic [SA_DIM*ACC_W-1:0]  row_data;

  logic [DATA_W-1:0] w_h [SA_DIM][SA_DIM+1];
  logic [DATA_W-1:0] x_v [SA_DIM+1][SA_DIM];
  logic [ACC_W-1:0]  acc [SA_DIM][SA_DIM];
  logic [2*SA_DIM*DATA_W-1:0] edge_unused;

  assign accept     = sa_start && (state_q == IDLE);
  assign sa_busy    = (state_q != IDLE);
  assign flush_done = (flush_cnt == 3'(FLUSH_CYC - 1));
  assign emit       = ((state_q == FLUSH) && flush_done) ||
                      ((state_q == DRAIN) && !sa_o_last);
  assign inj_w      = ((state_q == LOAD) && sa_i_vaild) ? sa_weight : '0;
  assign inj_x      = ((state_q == LOAD) && sa_i_vaild) ? sa_input  : '0;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sa_start)   state_d = LOAD;
      LOAD:    if (sa_i_last)  state_d = FLUSH;
      FLUSH:   if (flush_done) state_d = DRAIN;
      DRAIN:   if (sa_o_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, row-enable latch and flush counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      flush_cnt <= '0;
      row_en_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) row_en_q <= sa_row_en;
      if (state_q == LOAD)       flush_cnt <= '0;
      else if (state_q == FLUSH) flush_cnt <= flush_cnt + 3'd1;
    end
  end

  // Pick the next enabled row to emit and whether it is the final one.
  always_comb begin
    en4       = {row_en_q, 1'b1};
    start_idx = (state_q == FLUSH) ? 3'd0 : ({1'b0, cur_row} + 3'd1);
    nxt_row   = '0;
    found     = 1'b0;
    nxt_last  = 1'b1;
    row_data  = '0;
    for (int unsigned i = 0; i < SA_DIM; i++) begin
      if (!found && (i >= 32'(start_idx)) && en4[i[ROW_W-1:0]]) begin
        nxt_row = ROW_W'(i);
        found   = 1'b1;
      end
    end
    for (int unsigned i = 0; i < SA_DIM; i++) begin
      if ((i > 32'(nxt_row)) && en4[i[ROW_W-1:0]]) nxt_last = 1'b0;
    end
    for (int unsigned c = 0; c < SA_DIM; c++) begin
      row_data[c*ACC_W +: ACC_W] = acc[nxt_row][c];
    end
  end

  // Registered result row output; data holds between tiles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_o_valid <= 1'b0;
      sa_o_last  <= 1'b0;
      sa_o_data  <= '0;
      cur_row    <= '0;
    end else if (emit) begin
      sa_o_valid <= 1'b1;
      sa_o_last  <= nxt_last;
      sa_o_data  <= row_data;
      cur_row    <= nxt_row;
    end else if (state_q == DRAIN) begin
      sa_o_valid <= 1'b0;
      sa_o_last  <= 1'b0;
    end
  end

  // Row/column skew: lane 0 feeds the array combinationally so the far corner
  // finishes one cycle before the last flush edge, letting the drain register
  // capture row 0 on the FLUSH->DRAIN edge.
  for (genvar r = 0; r < SA_DIM; r++) begin : g_skew
    if (r == 0) begin : g_direct
      assign w_h[0][0] = lane_slice(inj_w, 0);
      assign x_v[0][0] = lane_slice(inj_x, 0);
    end else begin : g_delay
      logic [DATA_W-1:0] w_sh [r];
      logic [DATA_W-1:0] x_sh [r];
      // Delay lane r by r cycles; cleared on tile accept.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned k = 0; k < r; k++) begin
            w_sh[k] <= '0;
            x_sh[k] <= '0;
          end
        end else if (accept) begin
          for (int unsigned k = 0; k < r; k++) begin
            w_sh[k] <= '0;
            x_sh[k] <= '0;
          end
        end else begin
          w_sh[0] <= lane_slice(inj_w, r);
          x_sh[0] <= lane_slice(inj_x, r);
          for (int unsigned k = 1; k < r; k++) begin
            w_sh[k] <= w_sh[k-1];
            x_sh[k] <= x_sh[k-1];
          end
        end
      end
      assign w_h[r][0] = w_sh[r-1];
      assign x_v[0][r] = x_sh[r-1];
    end
  end

  for (genvar r = 0; r < SA_DIM; r++) begin : g_row
    for (genvar c = 0; c < SA_DIM; c++) begin : g_col
      sa_pe #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W)
      ) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .w_in  (w_h[r][c]),
        .x_in  (x_v[r][c]),
        .w_out (w_h[r][c+1]),
        .x_out (x_v[r+1][c]),
        .acc   (acc[r][c])
      );
    end
  end

  for (genvar i = 0; i < SA_DIM; i++) begin : g_edge
    assign edge_unused[i*DATA_W +: DATA_W]          = w_h[i][SA_DIM];
    assign edge_unused[(SA_DIM+i)*DATA_W +: DATA_W] = x_v[SA_DIM][i];
  end

endmodule

// File: tb/tb_sa_core.sv
// Directed self-checking bench for sa_core.
module tb_sa_core;

  logic         clk;
  logic         rst_n;
  logic         sa_start;
  logic         sa_busy;
  logic [2:0]   sa_row_en;
  logic         sa_i_vaild;
  logic         sa_i_last;
  logic [31:0]  sa_weight;
  logic [31:0]  sa_input;
  logic         sa_o_valid;
  logic         sa_o_last;
  logic [127:0] sa_o_data;

  int    errors = 0;
  int    checks = 0;
  string tname  = "init";

  sa_core #(
    .ACC_W  (32),
    .DATA_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sa_start   (sa_start),
    .sa_busy    (sa_busy),
    .sa_row_en  (sa_row_en),
    .sa_i_vaild (sa_i_vaild),
    .sa_i_last  (sa_i_last),
    .sa_weight  (sa_weight),
    .sa_input   (sa_input),
    .sa_o_valid (sa_o_valid),
    .sa_o_last  (sa_o_last),
    .sa_o_data  (sa_o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s got=%h exp=%h", tname, tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rep(input logic [31:0] v);
    return {4{v}};
  endfunction

  // Raise start for one edge, then scramble row_en (must be ignored after accept).
  task automatic start_tile(input logic [2:0] en);
    sa_start  = 1'b1;
    sa_row_en = en;
    @(posedge clk); #1;
    sa_start  = 1'b0;
    sa_row_en = ~en;
    @(negedge clk);
    check("busy_after_accept", sa_busy, 1'b1);
  endtask

  task automatic send_beat(input logic [31:0] w, input logic [31:0] x,
                           input logic v, input logic l);
    sa_weight  = w;
    sa_input   = x;
    sa_i_vaild = v;
    sa_i_last  = l;
    @(posedge clk); #1;
  endtask

  // Called one step after the edge that sampled sa_i_last (edge L). Checks
  // cycles L+1 .. L+8+n; junk operands are driven throughout and must be ignored.
  task automatic expect_drain(input logic [2:0] en, input logic [127:0] e0,
                              input logic [127:0] e1, input logic [127:0] e2,
                              input logic [127:0] e3);
    logic [127:0] rows [4];
    logic [127:0] exp_q [4];
    int n;
    logic exp_v;
    rows[0] = e0; rows[1] = e1; rows[2] = e2; rows[3] = e3;
    n = 0;
    for (int r = 0; r < 4; r++) begin
      if (r == 0 || en[r-1]) begin
        exp_q[n] = rows[r];
        n++;
      end
    end
    sa_i_vaild = 1'b1;
    sa_i_last  = 1'b1;
    sa_weight  = $urandom;
    sa_input   = $urandom;
    for (int k = 1; k <= 8 + n; k++) begin
      @(negedge clk);
      exp_v = (k >= 8) && (k <= 7 + n);
      check($sformatf("valid@L+%0d", k), sa_o_valid, exp_v);
      check($sformatf("last@L+%0d", k), sa_o_last, (k == 7 + n));
      check($sformatf("busy@L+%0d", k), sa_busy, (k < 8 + n));
      if (exp_v) check($sformatf("data@L+%0d", k), sa_o_data, exp_q[k-8]);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    sa_start   = 1'b0;
    sa_row_en  = 3'b000;
    sa_i_vaild = 1'b0;
    sa_i_last  = 1'b0;
    sa_weight  = '0;
    sa_input   = '0;

    tname = "reset";
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("busy", sa_busy, 1'b0);
    check("valid", sa_o_valid, 1'b0);
    check("last", sa_o_last, 1'b0);
    check("data", sa_o_data, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    tname = "k1_rows";
    start_tile(3'b111);
    send_beat(32'h04030201, 32'h01010101, 1'b1, 1'b1);
    expect_drain(3'b111, rep(32'd1), rep(32'd2), rep(32'd3), rep(32'd4));

    // Negative weights against per-column inputs: acc[r][c] = -(c+1).
    tname = "k1_cols_neg";
    start_tile(3'b011);
    send_beat(32'hFFFFFFFF, 32'h04030201, 1'b1, 1'b1);
    expect_drain(3'b011,
                 {32'hFFFFFFFC, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF},
                 {32'hFFFFFFFC, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF},
                 {32'hFFFFFFFC, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF},
                 128'd0);

    tname = "k2_signed";
    start_tile(3'b111);
    send_beat(32'hFFFFFFFF, 32'h80808080, 1'b1, 1'b0);
    send_beat(32'h02020202, 32'h03030303, 1'b1, 1'b1);
    expect_drain(3'b111, rep(32'd134), rep(32'd134), rep(32'd134), rep(32'd134));

    tname = "k256";
    start_tile(3'b111);
    for (int i = 0; i < 256; i++) send_beat(32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1, (i == 255));
    expect_drain(3'b111, rep(32'd4129024), rep(32'd4129024), rep(32'd4129024), rep(32'd4129024));

    tname = "k256_bubbles";
    start_tile(3'b111);
    for (int i = 0; i < 256; i++) begin
      if (i == 10 || i == 100 || i == 200) send_beat(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0);
      send_beat(32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1, (i == 255));
    end
    expect_drain(3'b111, rep(32'd4129024), rep(32'd4129024), rep(32'd4129024), rep(32'd4129024));

    tname = "rowen_001";
    start_tile(3'b001);
    send_beat(32'h04030201, 32'h01010101, 1'b1, 1'b1);
    expect_drain(3'b001, rep(32'd1), rep(32'd2), rep(32'd3), rep(32'd4));

    tname = "rowen_001_late_last";
    start_tile(3'b001);
    send_beat(32'h04030201, 32'h01010101, 1'b1, 1'b0);
    send_beat(32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b1);
    expect_drain(3'b001, rep(32'd1), rep(32'd2), rep(32'd3), rep(32'd4));

    tname = "rowen_100_skip";
    start_tile(3'b100);
    send_beat(32'h04030201, 32'h01010101, 1'b1, 1'b1);
    expect_drain(3'b100, rep(32'd1), rep(32'd2), rep(32'd3), rep(32'd4));

    // Start held high: each new tile is accepted on the busy-fall edge.
    tname = "held_start";
    sa_row_en = 3'b111;
    sa_start  = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check($sformatf("busy_tile%0d", t), sa_busy, 1'b1);
      send_beat(32'h04030201, 32'h01010101, 1'b1, 1'b1);
      expect_drain(3'b111, rep(32'd1), rep(32'd2), rep(32'd3), rep(32'd4));
    end
    // A fourth tile has been accepted; finish it with K=0.
    tname = "k0";
    sa_start = 1'b0;
    @(negedge clk);
    check("busy", sa_busy, 1'b1);
    send_beat(32'h11111111, 32'h22222222, 1'b0, 1'b1);
    expect_drain(3'b111, 128'd0, 128'd0, 128'd0, 128'd0);

    tname = "reset_mid_load";
    start_tile(3'b111);
    for (int i = 0; i < 5; i++) send_beat(32'h05050505, 32'h07070707, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("busy", sa_busy, 1'b0);
    check("valid", sa_o_valid, 1'b0);
    check("last", sa_o_last, 1'b0);
    check("data", sa_o_data, 128'd0);
    sa_i_vaild = 1'b0;
    sa_i_last  = 1'b0;
    #4;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tname = "after_reset_k1";
    start_tile(3'b111);
    send_beat(32'h04030201, 32'h01010101, 1'b1, 1'b1);
    expect_drain(3'b111, rep(32'd1), rep(32'd2), rep(32'd3), rep(32'd4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sa_core.md
# sa_core

4x4 output-stationary int8 systolic array; the compute engine on the far side of the matmul controller's `sa_*` interface. It accepts a start handshake and a stream of K packed weight/input beats, accumulating outer products in 32-bit PEs. It then drains one 4-column result row per cycle with valid/last strobes, which the controller writes to C memory.

## Interface
- `ACC_W`, 32: accumulator / output lane width.
- `DATA_W`, 8: operand lane width (signed two's complement).
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `sa_start` input 1: request a new tile; accepted when `sa_start & ~sa_busy`.
- `sa_busy` output 1: tile in progress; reset 0.
- `sa_row_en` input 3: bit r-1 enables output row r (r=1..3); row 0 is always enabled; sampled at accept.
- `sa_i_vaild` input 1: operand beat valid (port name spelled as on the controller).
- `sa_i_last` input 1: end of operand stream.
- `sa_weight` input 32: byte r = weight for row r.
- `sa_input` input 32: byte c = input for column c.
- `sa_o_valid` output 1: result row valid; reset 0.
- `sa_o_last` output 1: last enabled row of the tile; reset 0.
- `sa_o_data` output 4*ACC_W: bits [32c+31:32c] = acc[row][c]; reset 0.

## Operation
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE -> LOAD on accept. On accept: latch `sa_row_en`, clear all 16 accumulators and skew registers.
- LOAD:
  - Each cycle with `sa_i_vaild`=1 injects one beat.
  - Weight byte r enters row r delayed r cycles; input byte c enters column c delayed c cycles.
  - Each PE computes acc += w*x (signed 8x8 -> 16, sign-extended, mod 2^32), passes w right and x down.
  - Cycles with `sa_i_vaild`=0 inject zero bubbles.
- LOAD -> FLUSH on `sa_i_last`=1, independent of `sa_i_vaild`. A beat valid in the same cycle is included. K=0 (last with no beats) yields all-zero results.
- FLUSH: 7 cycles of zero injection (2*(4-1)+1), then -> DRAIN.
- DRAIN:
  - Emit enabled rows in ascending order, one per cycle, skipping disabled rows.
  - `sa_o_last` is high with the final emitted row.
  - Row count is 1..4.
- DRAIN -> IDLE after the `sa_o_last` cycle.
- Ignored inputs:
  - `sa_start` while busy.
  - `sa_i_vaild` / `sa_i_last` outside LOAD.
  - `sa_row_en` changes after accept.
- Async reset at any point (mid LOAD/FLUSH/DRAIN): return to IDLE, clear all outputs and accumulators. No partial row is emitted.

## Timing
- Accept sampled at edge T; `sa_busy`=1 from T+1. Beats are sampled from T+1 onward; the first controller beat arrives at T+1.
- Cycle L carries `sa_i_last`: FLUSH occupies L+1..L+7; first `sa_o_valid` at L+8.
- `sa_o_valid` is contiguous for n enabled rows: L+8..L+7+n. `sa_o_last` is at L+7+n.
- `sa_busy` falls at L+8+n. A start held high is accepted at that edge, giving one idle cycle between tiles.
- `sa_o_data` is registered; it holds its last value when `sa_o_valid`=0.

## Structure
- Package `sa_pkg`: `SA_DIM`=4, `FLUSH_CYC`=2*SA_DIM-1, FSM state enum, lane-slice helper.
- Sub-module `sa_pe`: one PE.
  - Ports: clk, rst_n, clr, w_in/x_in, w_out/x_out, acc.
  - 16 instances via generate.
- Top owns the FSM, skew shift registers, flush/drain counters and the output row mux.

## Test plan
- K=1, weight 0x04030201, input 0x01010101, row_en 3'b111 -> 4 valid rows; row r, all columns = r+1; `sa_o_last` on row 3 at L+11.
- K=2: beats (0xFFFFFFFF, 0x80808080) then (0x02020202, 0x03030303) -> every lane = 128+6 = 134.
- K=256, all bytes 0x7F -> every lane 4129024. Also insert 3 mid-stream bubbles (`sa_i_vaild`=0) and check the result is unchanged.
- row_en 3'b001 -> exactly 2 valid cycles (rows 0, 1), `sa_o_last` on the second; `sa_busy` falls next cycle. Separately, `sa_i_last` one cycle after the final valid beat gives the same result.
- `sa_start` held high across 3 tiles -> each accepted one cycle after the previous `sa_busy` fall; accumulators cleared per tile.
- `rst_n` low mid-LOAD (after 5 beats) -> `sa_busy`/`sa_o_valid` are 0 immediately. A new K=1 tile then produces clean results with no residue.
